// File: rtl/regfile_pkg.sv
// Shared clear-FSM encoding and default parameters for the multi-port register file.
package regfile_pkg;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_state_t;

  localparam int DEF_DW       = 32;
  localparam int DEF_AW       = 5;
  localparam int DEF_NR       = 2;
  localparam int DEF_NW       = 2;
  localparam int DEF_ZERO_REG = 1;
  localparam int DEF_BYPASS   = 1;
endpackage

// File: rtl/reg_file_mp_if.sv
// Read/write/clear bus of the register file; master drives requests, slave returns data and Busy.
interface reg_file_mp_if
  import regfile_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int NR = DEF_NR,
  parameter int NW = DEF_NW
);
  logic [NR*AW-1:0]   RAddr;
  logic [NR*DW-1:0]   RData;
  logic [NW-1:0]      WEn;
  logic [NW*AW-1:0]   WAddr;
  logic [NW*DW-1:0]   WData;
  logic [NW*DW/8-1:0] WBe;
  logic               ClrReq;
  logic               Busy;

  modport master (output RAddr, WEn, WAddr, WData, WBe, ClrReq, input RData, Busy);
  modport slave  (input RAddr, WEn, WAddr, WData, WBe, ClrReq, output RData, Busy);
endinterface

// File: rtl/regfile_wmerge.sv
// Byte-merges all enabled writes aimed at one address onto its current value; higher ports win per byte.
module regfile_wmerge #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NW = 2
) (
  input  logic [DW-1:0]      base,
  input  logic [AW-1:0]      addr,
  input  logic [NW-1:0]      wen,
  input  logic [NW*AW-1:0]   waddr,
  input  logic [NW*DW-1:0]   wdata,
  input  logic [NW*DW/8-1:0] wbe,
  output logic [DW-1:0]      merged
);
  localparam int NB = DW / 8;

  // Ascending port order lets the last (highest) matching port own each byte.
  always_comb begin
    merged = base;
    for (int j = 0; j < NW; j++) begin
      if (wen[j] && (waddr[j*AW +: AW] == addr)) begin
        for (int b = 0; b < NB; b++) begin
          if (wbe[j*NB + b]) begin
            merged[b*8 +: 8] = wdata[j*DW + b*8 +: 8];
          end
        end
      end
    end
  end
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with combinational reads, byte-enabled prioritised writes, optional bypass
// and a DEPTH-cycle zeroing sweep started by reset or ClrReq.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int NR       = DEF_NR,
  parameter int NW       = DEF_NW,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = DEF_BYPASS
) (
  input logic          CLK,
  input logic          Reset,
  reg_file_mp_if.slave bus
);
  localparam int DEPTH = 1 << AW;

  clr_state_t     state, state_nxt;
  logic [AW-1:0]  cnt, cnt_nxt;
  logic [NW-1:0]  wen_eff;
  logic [DW-1:0]  mem    [DEPTH];
  logic [DW-1:0]  merged [DEPTH];

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.ClrReq) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == AW'(DEPTH - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.Busy = (state == CLEAR);
  assign wen_eff  = (state == IDLE) ? bus.WEn : '0;

  // One merge per entry: its output is both the next stored value and the bypass read value.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    regfile_wmerge #(.DW(DW), .AW(AW), .NW(NW)) u_wmerge (
      .base   (mem[i]),
      .addr   (AW'(i)),
      .wen    (wen_eff),
      .waddr  (bus.WAddr),
      .wdata  (bus.WData),
      .wbe    (bus.WBe),
      .merged (merged[i])
    );
  end

  // Storage has no reset; it is zeroed only by the sweep.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (state == CLEAR) begin
        if (cnt == AW'(i)) mem[i] <= '0;
      end else if (ZERO_REG == 0 || i != 0) begin
        mem[i] <= merged[i];
      end
    end
  end

  always_comb begin
    bus.RData = '0;
    for (int k = 0; k < NR; k++) begin
      if (state == IDLE && !(ZERO_REG != 0 && bus.RAddr[k*AW +: AW] == '0)) begin
        bus.RData[k*DW +: DW] = (BYPASS != 0) ? merged[bus.RAddr[k*AW +: AW]]
                                              : mem[bus.RAddr[k*AW +: AW]];
      end
    end
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised scoreboard bench for reg_file_mp against an array-based reference model.
module tb_reg_file_mp;
  localparam int DW = 32, AW = 5, NR = 2, NW = 2, NB = DW / 8, DEPTH = 32;

  typedef struct packed {
    logic [NR*DW-1:0] rdata;
    logic             busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_mp_if #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) bus ();
  reg_file_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .ZERO_REG(1), .BYPASS(1)) dut (
    .CLK(clk), .Reset(rst), .bus(bus)
  );

  logic [DW-1:0] model_mem [DEPTH];
  int            sweep;  // next entry the sweep zeroes, -1 when idle
  int            checks = 0;
  int            failures = 0;
  exp_t          exp_q[$];
  string         tag_q[$];

  // Value address a holds after this cycle's writes land (bytes overwritten in port order).
  function automatic logic [DW-1:0] after_writes(input int a);
    logic [DW-1:0] v;
    v = model_mem[a];
    for (int j = 0; j < NW; j++)
      if (bus.WEn[j] && int'(bus.WAddr[j*AW +: AW]) == a)
        for (int b = 0; b < NB; b++)
          if (bus.WBe[j*NB + b]) v[b*8 +: 8] = bus.WData[j*DW + b*8 +: 8];
    return v;
  endfunction

  task automatic set_in(input logic [NW-1:0] wen, input int wa1, input int wa0,
                        input logic [DW-1:0] wd1, input logic [DW-1:0] wd0,
                        input logic [NW*NB-1:0] wbe, input int ra1, input int ra0,
                        input logic clr);
    bus.WEn    = wen;
    bus.WAddr  = {AW'(wa1), AW'(wa0)};
    bus.WData  = {wd1, wd0};
    bus.WBe    = wbe;
    bus.RAddr  = {AW'(ra1), AW'(ra0)};
    bus.ClrReq = clr;
  endtask

  task automatic rand_in(input bit allow_clr);
    int wa1, wa0, ra1, ra0;
    wa1 = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1);
    wa0 = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1);
    ra1 = ($urandom_range(0, 1) != 0) ? wa1 : $urandom_range(0, DEPTH - 1);
    ra0 = ($urandom_range(0, 1) != 0) ? wa0 : $urandom_range(0, DEPTH - 1);
    set_in(NW'($urandom), wa1, wa0, $urandom, $urandom, (NW*NB)'($urandom), ra1, ra0,
           allow_clr && ($urandom_range(0, 3) == 0));
  endtask

  // Push this cycle's expectation, then advance the model across the rising edge.
  task automatic step(input string tag);
    exp_t          e;
    int            a;
    logic [DW-1:0] nv [DEPTH];
    e.busy  = (sweep >= 0);
    e.rdata = '0;
    for (int k = 0; k < NR; k++) begin
      a = int'(bus.RAddr[k*AW +: AW]);
      if (!e.busy && a != 0) e.rdata[k*DW +: DW] = after_writes(a);
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    if (rst) begin
      sweep = 0;
      model_mem[0] = '0;
    end else if (sweep >= 0) begin
      model_mem[sweep] = '0;
      sweep++;
      if (sweep == DEPTH) sweep = -1;
    end else begin
      for (int i = 1; i < DEPTH; i++) nv[i] = after_writes(i);
      for (int i = 1; i < DEPTH; i++) model_mem[i] = nv[i];
      if (bus.ClrReq) sweep = 0;
    end
    #1;
  endtask

  task automatic readback(input string tag);
    for (int a = 0; a < DEPTH; a += 2) begin
      set_in('0, 0, 0, '0, '0, '0, a + 1, a, 1'b0);
      step(tag);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t  e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (bus.Busy !== e.busy) begin
        failures++;
        $display("FAIL %s busy: got %0b expected %0b at %0t", t, bus.Busy, e.busy, $time);
      end
      for (int k = 0; k < NR; k++) begin
        checks++;
        if (bus.RData[k*DW +: DW] !== e.rdata[k*DW +: DW]) begin
          failures++;
          $display("FAIL %s rdata[%0d] addr %0d: got %h expected %h at %0t", t, k,
                   bus.RAddr[k*AW +: AW], bus.RData[k*DW +: DW], e.rdata[k*DW +: DW], $time);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'hA5A5_0000 + DW'(i);
    sweep = 0;
    set_in('0, 0, 0, '0, '0, '0, 0, 3, 1'b0);
    @(posedge clk);
    #1;

    // Power-on reset, then a full sweep with random writes that must be ignored.
    repeat (3) begin rand_in(1'b0); step("reset_hold"); end
    rst = 1'b0;
    repeat (DEPTH) begin rand_in(1'b1); step("reset_sweep"); end
    set_in('0, 0, 0, '0, '0, '0, 1, 3, 1'b0);
    step("post_sweep_idle");

    // Byte-merged overwrite from the second port.
    set_in(2'b01, 0, 3, '0, 32'hDEADBEEF, 8'h0F, 0, 3, 1'b0); step("wr_full");
    set_in(2'b10, 3, 0, 32'h12, '0, 8'h10, 3, 3, 1'b0);      step("wr_byte_bypass");
    set_in('0, 0, 0, '0, '0, '0, 3, 3, 1'b0);                 step("rd_merged");
    // Two ports to the same address: higher port wins.
    set_in(2'b11, 5, 5, 32'h22222222, 32'h11111111, 8'hFF, 5, 5, 1'b0); step("collide_bypass");
    set_in('0, 0, 0, '0, '0, '0, 5, 5, 1'b0);                            step("collide_after");
    // Address 0 stays zero.
    set_in(2'b11, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 0, 0, 1'b0); step("zero_reg_bypass");
    set_in('0, 0, 0, '0, '0, '0, 0, 0, 1'b0);                            step("zero_reg_after");
    // Enabled write with no bytes selected.
    set_in(2'b11, 3, 5, 32'h0BAD0BAD, 32'h0BAD0BAD, 8'h00, 3, 5, 1'b0); step("wbe_zero");

    repeat (300) begin rand_in(1'b0); step("random"); end
    readback("random_readback");

    // Fill, then clear together with a same-edge write to address 7.
    for (int a = 1; a < DEPTH; a++) begin
      set_in(2'b01, 0, a, '0, $urandom, 8'h0F, 0, a, 1'b0);
      step("fill");
    end
    set_in(2'b01, 0, 7, '0, 32'hCAFEF00D, 8'h0F, 7, 7, 1'b1); step("clr_with_write");
    repeat (DEPTH) begin rand_in(1'b1); step("clr_sweep"); end
    readback("clr_readback");

    // Reset arriving ten edges into a sweep restarts it.
    repeat (40) begin rand_in(1'b0); step("refill"); end
    set_in('0, 0, 0, '0, '0, '0, 1, 2, 1'b1); step("clr_start");
    repeat (10) begin rand_in(1'b1); step("clr_partial"); end
    rst = 1'b1;
    sweep = 0;
    repeat (2) begin rand_in(1'b1); step("mid_reset_hold"); end
    rst = 1'b0;
    repeat (DEPTH) begin rand_in(1'b1); step("restart_sweep"); end
    readback("restart_readback");
    repeat (50) begin rand_in(1'b0); step("random_tail"); end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits, a multiple of 8.
REQ-002 SHALL have parameter AW, default 5, address width; DEPTH = 2**AW entries.
REQ-003 SHALL have parameter NR, default 2, number of read ports.
REQ-004 SHALL have parameter NW, default 2, number of write ports.
REQ-005 SHALL have parameter ZERO_REG, default 1; 1 = entry 0 reads 0 and ignores writes.
REQ-006 SHALL have parameter BYPASS, default 1; 1 = same-cycle write data forwarded to reads.
REQ-007 SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-008 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port RAddr  input  NR*AW  read addresses, port k in bits [k*AW +: AW].
REQ-010 SHALL have port RData  output  NR*DW  read data, port k in bits [k*DW +: DW].
REQ-011 SHALL have port WEn  input  NW  per-port write enable.
REQ-012 SHALL have port WAddr  input  NW*AW  write addresses, packed like RAddr.
REQ-013 SHALL have port WData  input  NW*DW  write data, packed like RData.
REQ-014 SHALL have port WBe  input  NW*DW/8  per-port byte enables, port j in bits [j*DW/8 +: DW/8].
REQ-015 SHALL have port ClrReq  input  1  request to zero the whole file.
REQ-016 SHALL have port Busy  output  1  high while a clear sweep is in progress.

Function
REQ-017 Reads SHALL be combinational: RData port k = entry[RAddr k] with no clock latency.
REQ-018 A write SHALL update entry[WAddr j] at the rising edge where WEn[j]=1, only the bytes whose WBe bit is 1.
REQ-019 With WEn[j]=1 and WBe all-zero, no state SHALL change.
REQ-020 When several write ports hit the same address in one cycle, each byte SHALL take the value of the highest-index port enabling that byte.
REQ-021 With BYPASS=1, RData SHALL reflect this cycle's enabled writes to the same address (byte-merged per REQ-018/020) combinationally; with BYPASS=0, the pre-edge stored value.
REQ-022 With ZERO_REG=1, reads of address 0 SHALL return 0 and writes to address 0 SHALL be discarded, including bypass.
REQ-023 Clear FSM states SHALL be IDLE and CLEAR, with an AW-bit sweep counter.
REQ-024 In CLEAR, each rising edge SHALL zero entry[counter] and increment the counter; at counter = DEPTH-1 the next state SHALL be IDLE.
REQ-025 Busy SHALL be 1 exactly while state = CLEAR, giving DEPTH cycles of Busy per sweep.
REQ-026 In IDLE, ClrReq=1 at a rising edge SHALL move to CLEAR with counter = 0; the same-edge write SHALL still be performed.
REQ-027 In CLEAR, WEn SHALL be ignored and every RData SHALL read 0.
REQ-028 ClrReq during CLEAR SHALL be ignored; the sweep neither restarts nor extends.

Reset
REQ-029 Reset=1 SHALL asynchronously force state CLEAR, counter 0 and Busy=1; all RData read 0 immediately.
REQ-030 After Reset deasserts, the sweep SHALL run DEPTH rising edges; Busy SHALL fall after the DEPTH-th edge.
REQ-031 Reset asserted mid-sweep SHALL restart the sweep from counter 0.
REQ-032 Storage array contents SHALL NOT be reset directly; zeroing occurs only through the sweep.

Structure
REQ-033 State encoding (IDLE=0, CLEAR=1) and default parameter values SHALL live in a shared package, regfile_pkg.
REQ-034 The write-merge logic (byte enables plus port priority for one address) SHALL be one sub-module, regfile_wmerge, used by both the write path and the bypass path.
REQ-035 The sub-module SHALL be instantiated once per entry or once per read port; storage SHALL remain in reg_file_mp.

Verification
REQ-036 Pulse Reset, then release: Busy=1 for exactly 32 edges (default parameters); all RData = 0 throughout; Busy=0 afterwards.
REQ-037 Write port 0, address 3, 0xDEADBEEF, WBe=1111; then port 1, address 3, 0x00000012, WBe=0001: next read of address 3 = 0xDEADBE12.
REQ-038 Same cycle, port 0 writes 0x11111111 and port 1 writes 0x22222222, both to address 5 with WBe=1111: address 5 reads 0x22222222 after the edge; with BYPASS=1 it also reads 0x22222222 before the edge.
REQ-039 Write 0xFFFFFFFF to address 0: reads of address 0 return 0 before and after the edge.
REQ-040 Fill the file, assert ClrReq together with a write to address 7: 32 Busy cycles, writes during CLEAR ignored, all entries 0 at the end.
REQ-041 Assert Reset at sweep counter 10: Busy stays 1; sweep restarts from 0 and lasts 32 edges after release.
